seaquest_env_scheduler: RTL and testbench
=========================================

// Module: seaquest_env_scheduler
// PURPOSE
//  Time-shares one Seaquest Compute_Single step engine among N_ENV independent environments.
//  - Holds a per-environment state bank.
//  - Arbitrates step requests round-robin and drives the engine for one step.
//  - Writes the next state back to the bank and returns obs/reward/done, tagged with the env id.
//  - Sits between the agent-side request fabric and the engine; the engine keeps no per-env state.
// PARAMETERS
//  N_ENV    4     number of environments; 2..8
//  STA_WL   736   state width; matches engine
//  ACT_WL   3     action width
//  OBS_WL   736   observation width
//  RWD_WL   32    reward width
//  TMO_CYC  64    cycles to wait for i_eng_valid before aborting a step
// PORTS
//  i_clk         in   1               clock
//  i_rst         in   1               asynchronous reset, active-high
//  i_init_sta    in   STA_WL          episode start state, loaded on first step, done, or env reset
//  i_req_valid   in   N_ENV           per-env step request
//  i_req_act     in   N_ENV*ACT_WL    per-env action; env n at [n*ACT_WL +: ACT_WL]
//  o_req_ready   out  N_ENV           one-hot one-cycle accept pulse
//  i_env_reset   in   N_ENV           per-env pulse: force next step to start from i_init_sta
//  o_eng_ena     out  1               engine enable
//  o_eng_sta     out  STA_WL          state presented to engine
//  o_eng_act     out  ACT_WL          action presented to engine
//  i_eng_sta     in   STA_WL          engine next state
//  i_eng_obs     in   OBS_WL          engine observation
//  i_eng_rwd     in   RWD_WL          engine reward
//  i_eng_done    in   1               engine episode-end flag
//  i_eng_valid   in   1               engine result valid
//  o_rsp_valid   out  1               response valid; held until accepted
//  i_rsp_ready   in   1               response accept
//  o_rsp_env     out  clog2(N_ENV)    env id of response
//  o_rsp_obs     out  OBS_WL          observation
//  o_rsp_rwd     out  RWD_WL          reward
//  o_rsp_done    out  1               episode ended on this step
//  o_rsp_err     out  1               step aborted by timeout
//  o_rsp_step    out  16              step index within episode, after this step
// BEHAVIOUR
//  Reset values
//  - All outputs 0; FSM in IDLE.
//  - Round-robin pointer = N_ENV-1, so env 0 has first priority.
//  - All bank entries 0; all loaded[n]=0; all step counters 0.
//  FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE
//  - Select the first set i_req_valid bit at or above (ptr+1) mod N_ENV, with wrap-around.
//  - Same cycle: o_req_ready[sel]=1; latch sel and its action; ptr<=sel; go to ISSUE.
//  - No request: stay in IDLE.
//  ISSUE (1 cycle)
//  - o_eng_ena=1.
//  - o_eng_sta = loaded[sel] ? bank[sel] : i_init_sta.
//  - o_eng_act = latched action; clear timeout counter; go to WAIT.
//  WAIT
//  - o_eng_ena, o_eng_sta and o_eng_act held; counter increments each cycle.
//  - On i_eng_valid:
//    - bank[sel] <= i_eng_done ? i_init_sta : i_eng_sta; loaded[sel] <= 1.
//    - step[sel] <= i_eng_done ? 0 : step[sel]+1, wrapping at 16 bits.
//    - Register obs/rwd/done; err=0; o_eng_ena=0; go to RESP.
//    - o_rsp_step reports the pre-clear value +1.
//  - Counter reaches TMO_CYC-1 without valid:
//    - Bank and step unchanged; obs=0, rwd=0, done=0, err=1.
//    - o_eng_ena=0; go to RESP.
//  - Valid and timeout in the same cycle: valid wins.
//  RESP
//  - o_rsp_* stable and o_rsp_valid=1 until i_rsp_ready is sampled high.
//  - On accept: o_rsp_valid=0 next cycle; return to IDLE.
//  - Minimum request-to-request spacing per env is therefore 4 cycles.
//  i_env_reset[n]
//  - Clears loaded[n] and step[n] in any state.
//  - If n is in flight, it still wins over the WAIT writeback in the same or later cycles.
//    The in-flight response is still returned.
//  Requests: only accepted in IDLE; a requester holds i_req_valid until its o_req_ready pulse.
//  Async reset mid-step: aborts immediately; no response is produced.
// TESTING
//  1. Single env 0 step, engine valid after 3 cycles:
//     - o_eng_sta==i_init_sta; o_rsp_env=0; o_rsp_step=1; err=0.
//     - A second step presents the previous i_eng_sta.
//  2. All 4 envs request continuously:
//     - Grants go 0,1,2,3,0,...; no env is granted twice before the others.
//  3. Engine returns i_eng_done=1 on env 2:
//     - o_rsp_done=1.
//     - Env 2's next step presents i_init_sta, o_rsp_step=1.
//  4. Engine never asserts valid:
//     - o_rsp_err=1 after TMO_CYC cycles in WAIT; bank unchanged; the retry step uses the same state.
//  5. i_rsp_ready low for 10 cycles:
//     - o_rsp_* stable throughout; no new o_req_ready until accept.
//  6. i_env_reset[1] during env 1 WAIT:
//     - Response still returned; env 1's next step starts from i_init_sta, step=1.

Source files
------------

// File: rtl/seaquest_env_scheduler.sv
// ---------------------------------------------------------------------------
// seaquest_env_scheduler
//   Time-shares one Seaquest Compute_Single step engine among N_ENV
//   independent environments. Each environment's state lives in a local bank.
//   Step requests are granted round-robin. The granted environment's state and
//   action are driven into the engine for one step. The engine's next state is
//   written back to the bank, and obs/reward/done are returned tagged with the
//   environment id.
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_init_sta        episode start state (first step, after done, after env reset)
//   i_req_valid       per-env step request, held until its o_req_ready pulse
//   i_req_act         per-env action, env n at [n*ACT_WL +: ACT_WL]
//   o_req_ready       one-hot, one-cycle accept pulse
//   i_env_reset       per-env pulse forcing the next step to start from i_init_sta
//   o_eng_ena         engine enable (ISSUE and WAIT)
//   o_eng_sta/act     state and action presented to the engine
//   i_eng_*           engine result (next state, obs, reward, done, valid)
//   o_rsp_*           response to the agent, held until i_rsp_ready
// ---------------------------------------------------------------------------
module seaquest_env_scheduler #(
  parameter int N_ENV   = 4,
  parameter int STA_WL  = 736,
  parameter int ACT_WL  = 3,
  parameter int OBS_WL  = 736,
  parameter int RWD_WL  = 32,
  parameter int TMO_CYC = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [STA_WL-1:0]          i_init_sta,
  input  logic [N_ENV-1:0]           i_req_valid,
  input  logic [N_ENV*ACT_WL-1:0]    i_req_act,
  output logic [N_ENV-1:0]           o_req_ready,
  input  logic [N_ENV-1:0]           i_env_reset,
  output logic                       o_eng_ena,
  output logic [STA_WL-1:0]          o_eng_sta,
  output logic [ACT_WL-1:0]          o_eng_act,
  input  logic [STA_WL-1:0]          i_eng_sta,
  input  logic [OBS_WL-1:0]          i_eng_obs,
  input  logic [RWD_WL-1:0]          i_eng_rwd,
  input  logic                       i_eng_done,
  input  logic                       i_eng_valid,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [$clog2(N_ENV)-1:0]   o_rsp_env,
  output logic [OBS_WL-1:0]          o_rsp_obs,
  output logic [RWD_WL-1:0]          o_rsp_rwd,
  output logic                       o_rsp_done,
  output logic                       o_rsp_err,
  output logic [15:0]                o_rsp_step
);

  localparam int ENV_W = $clog2(N_ENV);
  localparam int TMO_W = $clog2(TMO_CYC) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;

  logic [ENV_W-1:0]    r_ptr;
  logic [ENV_W-1:0]    r_sel;
  logic [ACT_WL-1:0]   r_act;
  logic [STA_WL-1:0]   r_engSta;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_killed;

  logic [STA_WL-1:0]   r_bank [N_ENV];
  logic [N_ENV-1:0]    r_loaded;
  logic [15:0]         r_step [N_ENV];

  logic [OBS_WL-1:0]   r_rspObs;
  logic [RWD_WL-1:0]   r_rspRwd;
  logic                r_rspDone;
  logic                r_rspErr;
  logic [15:0]         r_rspStep;

  logic [ACT_WL-1:0]   w_actArr [N_ENV];
  logic                w_grant;
  logic [ENV_W-1:0]    w_sel;
  logic [ENV_W-1:0]    w_cand;
  logic [ACT_WL-1:0]   w_selAct;
  logic [STA_WL-1:0]   w_issueSta;
  logic                w_timeout;

  // Unpack the flat action bus so the arbiter can index it by env id.
  always_comb begin
    for (int n = 0; n < N_ENV; n++) begin
      w_actArr[n] = i_req_act[n*ACT_WL +: ACT_WL];
    end
  end

  // Round-robin arbiter: scan from the env after the last grant, wrapping,
  // and take the first requester found.
  always_comb begin
    w_grant  = 1'b0;
    w_sel    = '0;
    w_cand   = '0;
    w_selAct = '0;
    for (int i = 1; i <= N_ENV; i++) begin
      w_cand = ENV_W'((int'(r_ptr) + i) % N_ENV);
      if (!w_grant && i_req_valid[w_cand]) begin
        w_grant  = 1'b1;
        w_sel    = w_cand;
        w_selAct = w_actArr[w_cand];
      end
    end
  end

  // An env that has never stepped, just ended, or was reset starts from the
  // external episode start state instead of its bank entry.
  assign w_issueSta = r_loaded[r_sel] ? r_bank[r_sel] : i_init_sta;
  assign w_timeout  = (r_tmo == TMO_W'(TMO_CYC - 1));

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. A result arriving on the timeout cycle still counts as a result.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_grant) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (i_eng_valid || w_timeout) w_next = S_RESP;
      S_RESP:  if (i_rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic. The state shown in ISSUE is captured into r_engSta, so WAIT
  // keeps presenting it even if the env is reset or i_init_sta moves.
  always_comb begin
    o_req_ready = '0;
    if (r_state == S_IDLE && w_grant) begin
      o_req_ready[w_sel] = 1'b1;
    end
    o_eng_ena   = (r_state == S_ISSUE) || (r_state == S_WAIT);
    o_eng_sta   = (r_state == S_ISSUE) ? w_issueSta :
                  (r_state == S_WAIT)  ? r_engSta   : '0;
    o_eng_act   = o_eng_ena ? r_act : '0;
    o_rsp_valid = (r_state == S_RESP);
    o_rsp_env   = r_sel;
    o_rsp_obs   = r_rspObs;
    o_rsp_rwd   = r_rspRwd;
    o_rsp_done  = r_rspDone;
    o_rsp_err   = r_rspErr;
    o_rsp_step  = r_rspStep;
  end

  // Datapath: grant latching, timeout counter, bank/step writeback and the
  // response registers. r_killed records an env reset of the in-flight env
  // so a later writeback cannot mark it loaded again. The env-reset loop
  // comes last so it overrides a same-cycle writeback.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr     <= ENV_W'(N_ENV - 1);
      r_sel     <= '0;
      r_act     <= '0;
      r_engSta  <= '0;
      r_tmo     <= '0;
      r_killed  <= 1'b0;
      r_loaded  <= '0;
      r_rspObs  <= '0;
      r_rspRwd  <= '0;
      r_rspDone <= 1'b0;
      r_rspErr  <= 1'b0;
      r_rspStep <= '0;
      for (int n = 0; n < N_ENV; n++) begin
        r_bank[n] <= '0;
        r_step[n] <= '0;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_sel    <= w_sel;
            r_ptr    <= w_sel;
            r_act    <= w_selAct;
            r_killed <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_tmo    <= '0;
          r_engSta <= w_issueSta;
          if (i_env_reset[r_sel]) r_killed <= 1'b1;
        end
        S_WAIT: begin
          r_tmo <= r_tmo + 1'b1;
          if (i_env_reset[r_sel]) r_killed <= 1'b1;
          if (i_eng_valid) begin
            r_bank[r_sel] <= i_eng_done ? i_init_sta : i_eng_sta;
            if (!r_killed) begin
              r_loaded[r_sel] <= 1'b1;
              r_step[r_sel]   <= i_eng_done ? 16'd0 : r_step[r_sel] + 16'd1;
            end
            r_rspObs  <= i_eng_obs;
            r_rspRwd  <= i_eng_rwd;
            r_rspDone <= i_eng_done;
            r_rspErr  <= 1'b0;
            r_rspStep <= r_step[r_sel] + 16'd1;
          end else if (w_timeout) begin
            r_rspObs  <= '0;
            r_rspRwd  <= '0;
            r_rspDone <= 1'b0;
            r_rspErr  <= 1'b1;
            r_rspStep <= r_step[r_sel];
          end
        end
        default: ;
      endcase
      for (int n = 0; n < N_ENV; n++) begin
        if (i_env_reset[n]) begin
          r_loaded[n] <= 1'b0;
          r_step[n]   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seaquest_env_scheduler.sv
// ---------------------------------------------------------------------------
// tb_seaquest_env_scheduler
//   Directed bench for seaquest_env_scheduler. A behavioural model of the
//   state bank (mSta/mLoaded/mStep) supplies the expected engine state and
//   step index for every transaction. All checks go through checkOutput.
// ---------------------------------------------------------------------------
module tb_seaquest_env_scheduler;

  localparam int N_ENV   = 4;
  localparam int STA_WL  = 32;
  localparam int ACT_WL  = 3;
  localparam int OBS_WL  = 32;
  localparam int RWD_WL  = 32;
  localparam int TMO_CYC = 64;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [STA_WL-1:0]       initSta;
  logic [N_ENV-1:0]        reqValid;
  logic [N_ENV*ACT_WL-1:0] reqAct;
  logic [N_ENV-1:0]        reqReady;
  logic [N_ENV-1:0]        envReset;
  logic                    engEna;
  logic [STA_WL-1:0]       engStaOut;
  logic [ACT_WL-1:0]       engActOut;
  logic [STA_WL-1:0]       engSta;
  logic [OBS_WL-1:0]       engObs;
  logic [RWD_WL-1:0]       engRwd;
  logic                    engDone;
  logic                    engValid;
  logic                    rspValid;
  logic                    rspReady;
  logic [1:0]              rspEnv;
  logic [OBS_WL-1:0]       rspObs;
  logic [RWD_WL-1:0]       rspRwd;
  logic                    rspDone;
  logic                    rspErr;
  logic [15:0]             rspStep;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mSta    [N_ENV];
  bit          mLoaded [N_ENV];
  logic [15:0] mStep   [N_ENV];

  seaquest_env_scheduler #(
    .N_ENV(N_ENV), .STA_WL(STA_WL), .ACT_WL(ACT_WL),
    .OBS_WL(OBS_WL), .RWD_WL(RWD_WL), .TMO_CYC(TMO_CYC)
  ) dut (
    .i_clk(clock), .i_rst(reset), .i_init_sta(initSta),
    .i_req_valid(reqValid), .i_req_act(reqAct), .o_req_ready(reqReady),
    .i_env_reset(envReset),
    .o_eng_ena(engEna), .o_eng_sta(engStaOut), .o_eng_act(engActOut),
    .i_eng_sta(engSta), .i_eng_obs(engObs), .i_eng_rwd(engRwd),
    .i_eng_done(engDone), .i_eng_valid(engValid),
    .o_rsp_valid(rspValid), .i_rsp_ready(rspReady), .o_rsp_env(rspEnv),
    .o_rsp_obs(rspObs), .o_rsp_rwd(rspRwd), .o_rsp_done(rspDone),
    .o_rsp_err(rspErr), .o_rsp_step(rspStep)
  );

  always #5 clock = ~clock;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int n = 0; n < N_ENV; n++) begin
      mSta[n]    = '0;
      mLoaded[n] = 1'b0;
      mStep[n]   = '0;
    end
  endfunction

  // One full step for env, starting in IDLE. lat<0 means the engine never
  // answers. hold = cycles the response is left unaccepted, otherReq =
  // requests raised while this step is in flight, rstAt = WAIT cycle of an
  // env reset pulse (or -1).
  task automatic applyStimulus(input int env, input logic [3:0] reqMask,
                               input logic [3:0] otherReq, input logic [2:0] act,
                               input int lat, input logic [31:0] nxt,
                               input logic [31:0] obsV, input logic [31:0] rwdV,
                               input logic doneV, input int hold, input int rstAt);
    logic [31:0] expSta;
    logic [15:0] expStep;
    logic [31:0] snapObs;
    logic [15:0] snapStep;
    int          cyc;
    bit          got;
    expSta  = mLoaded[env] ? mSta[env] : initSta;
    expStep = mStep[env] + 16'd1;

    reqValid = reqMask;
    reqAct   = '0;
    reqAct[env*ACT_WL +: ACT_WL] = act;
    #1;
    checkOutput("grant", 64'(reqReady), 64'(4'b0001 << env));
    tick();
    reqValid = otherReq;
    checkOutput("issueEna", 64'(engEna), 64'd1);
    checkOutput("issueSta", 64'(engStaOut), 64'(expSta));
    checkOutput("issueAct", 64'(engActOut), 64'(act));
    tick();
    checkOutput("waitStaHeld", 64'(engStaOut), 64'(expSta));

    cyc = 0;
    got = 1'b0;
    while (!got && cyc < TMO_CYC + 4) begin
      if (rstAt == cyc) envReset[env] = 1'b1;
      engSta = nxt;
      engObs = obsV;
      engRwd = rwdV;
      engDone = doneV;
      engValid = (lat >= 0 && cyc == lat);
      tick();
      envReset = '0;
      engValid = 1'b0;
      cyc++;
      if (rspValid) got = 1'b1;
    end
    checkOutput("rspArrive", 64'(got), 64'd1);
    checkOutput("rspLatency", 64'(cyc), (lat >= 0) ? 64'(lat + 1) : 64'(TMO_CYC));
    checkOutput("rspEnv", 64'(rspEnv), 64'(env));
    checkOutput("engEnaLow", 64'(engEna), 64'd0);
    if (lat >= 0) begin
      checkOutput("rspObs", 64'(rspObs), 64'(obsV));
      checkOutput("rspRwd", 64'(rspRwd), 64'(rwdV));
      checkOutput("rspDone", 64'(rspDone), 64'(doneV));
      checkOutput("rspErr", 64'(rspErr), 64'd0);
      if (rstAt < 0) checkOutput("rspStep", 64'(rspStep), 64'(expStep));
    end else begin
      checkOutput("tmoObs", 64'(rspObs), 64'd0);
      checkOutput("tmoRwd", 64'(rspRwd), 64'd0);
      checkOutput("tmoDone", 64'(rspDone), 64'd0);
      checkOutput("tmoErr", 64'(rspErr), 64'd1);
    end

    snapObs  = rspObs;
    snapStep = rspStep;
    for (int h = 0; h < hold; h++) begin
      tick();
      checkOutput("holdValid", 64'(rspValid), 64'd1);
      checkOutput("holdObs", 64'(rspObs), 64'(snapObs));
      checkOutput("holdStep", 64'(rspStep), 64'(snapStep));
      checkOutput("holdNoGrant", 64'(reqReady), 64'd0);
    end

    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    reqValid = '0;
    checkOutput("rspDrop", 64'(rspValid), 64'd0);

    if (rstAt >= 0) begin
      mLoaded[env] = 1'b0;
      mStep[env]   = '0;
    end else if (lat >= 0) begin
      mLoaded[env] = 1'b1;
      if (doneV) begin
        mSta[env]  = initSta;
        mStep[env] = '0;
      end else begin
        mSta[env]  = nxt;
        mStep[env] = mStep[env] + 16'd1;
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    initSta  = 32'hA0A0_0000;
    reqValid = '0;
    reqAct   = '0;
    envReset = '0;
    engSta   = '0;
    engObs   = '0;
    engRwd   = '0;
    engDone  = 1'b0;
    engValid = 1'b0;
    rspReady = 1'b0;
    modelReset();

    tick();
    tick();
    checkOutput("rstRspValid", 64'(rspValid), 64'd0);
    checkOutput("rstEngEna", 64'(engEna), 64'd0);
    checkOutput("rstEngSta", 64'(engStaOut), 64'd0);
    checkOutput("rstReqReady", 64'(reqReady), 64'd0);
    checkOutput("rstRspStep", 64'(rspStep), 64'd0);
    reset = 1'b0;
    tick();

    $display("[TB] single env 0 steps");
    applyStimulus(0, 4'b0001, 4'b0000, 3'd5, 3, 32'h1111_0001, 32'h0B50_0001,
                  32'd7, 1'b0, 0, -1);
    applyStimulus(0, 4'b0001, 4'b0000, 3'd2, 0, 32'h1111_0002, 32'h0B50_0002,
                  32'd9, 1'b0, 0, -1);

    $display("[TB] round-robin with all envs requesting");
    for (int g = 0; g < 8; g++) begin
      applyStimulus((g + 1) % N_ENV, 4'hF, 4'hF, 3'(g), g % 3,
                    32'h2000_0000 + 32'(g), 32'h3000_0000 + 32'(g),
                    32'(g), 1'b0, 0, -1);
    end

    $display("[TB] episode end on env 2");
    applyStimulus(2, 4'b0100, 4'b0000, 3'd1, 1, 32'hDEAD_0002, 32'h4000_0002,
                  32'hFFFF_FFFF, 1'b1, 0, -1);
    applyStimulus(2, 4'b0100, 4'b0000, 3'd3, 2, 32'h4444_0002, 32'h4000_0003,
                  32'd1, 1'b0, 0, -1);

    $display("[TB] engine timeout on env 3 and retry");
    applyStimulus(3, 4'b1000, 4'b0000, 3'd6, -1, 32'hBAD0_0003, 32'h5555_5555,
                  32'h6666_6666, 1'b1, 0, -1);
    applyStimulus(3, 4'b1000, 4'b0000, 3'd6, 0, 32'h5000_0003, 32'h5000_0013,
                  32'd3, 1'b0, 0, -1);

    $display("[TB] valid on the timeout cycle");
    applyStimulus(0, 4'b0001, 4'b0000, 3'd4, TMO_CYC - 1, 32'h6000_0000,
                  32'h6000_0010, 32'd11, 1'b0, 0, -1);

    $display("[TB] response back-pressure");
    applyStimulus(1, 4'b0010, 4'b0001, 3'd7, 1, 32'h7000_0001, 32'h7000_0011,
                  32'd13, 1'b0, 10, -1);

    $display("[TB] env reset while env 1 is in flight");
    applyStimulus(1, 4'b0010, 4'b0000, 3'd0, 3, 32'h8000_0001, 32'h8000_0011,
                  32'd15, 1'b0, 0, 0);
    applyStimulus(1, 4'b0010, 4'b0000, 3'd2, 1, 32'h9000_0001, 32'h9000_0011,
                  32'd17, 1'b0, 0, -1);

    $display("[TB] async reset mid-step");
    reqValid = 4'b0100;
    tick();
    reqValid = '0;
    tick();
    reset = 1'b1;
    #1;
    checkOutput("midRstEngEna", 64'(engEna), 64'd0);
    checkOutput("midRstRspValid", 64'(rspValid), 64'd0);
    tick();
    reset = 1'b0;
    modelReset();
    tick();
    applyStimulus(0, 4'b1001, 4'b0000, 3'd1, 0, 32'hA000_0000, 32'hA000_0010,
                  32'd19, 1'b0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
